// File: rtl/ca_pkg.sv
// Shared constants and state encoding for the C/A code correlator.
package ca_pkg;

  localparam int unsigned CHIPS_PER_EPOCH = 1023;
  localparam int unsigned ACC_W_DEFAULT   = 12;
  localparam int unsigned CNT_W           = 10;

  typedef enum logic [0:0] {
    WAIT_SYNC,
    ACCUM
  } state_e;

endpackage

// File: rtl/epoch_counter.sv
// Chip counter for one code epoch, with terminal-count flag at CHIPS-1.
module epoch_counter
  import ca_pkg::*;
#(
  parameter int unsigned CHIPS = CHIPS_PER_EPOCH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_comb begin
    last = (count == CNT_W'(CHIPS - 1));
  end

  // A clear with a simultaneous enable counts that chip as the first of a new epoch.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= enable ? CNT_W'(1) : '0;
    end else if (enable) begin
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ca_correlator.sv
// 1-bit sign correlator: accumulates +/-1 chip products over an epoch and dumps
// the sum through a valid/ready output register with a sticky overrun flag.
module ca_correlator
  import ca_pkg::*;
#(
  parameter int unsigned CHIPS = CHIPS_PER_EPOCH,
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_sample,
  input  logic             in_code,
  input  logic             chip_stb,
  input  logic             sync,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] chip_cnt
);

  state_e state, state_next;

  logic                    restart;
  logic                    chip_take;
  logic                    dump;
  logic                    cnt_last;
  logic                    xfer;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      WAIT_SYNC: if (sync) state_next = ACCUM;
      ACCUM:     state_next = ACCUM;
    endcase
  end

  // sync always restarts the epoch and outranks the dump condition.
  always_comb begin
    restart   = 1'b0;
    chip_take = 1'b0;
    dump      = 1'b0;
    unique case (state)
      WAIT_SYNC: begin
        restart   = sync;
        chip_take = sync && chip_stb;
      end
      ACCUM: begin
        restart   = sync;
        chip_take = chip_stb;
        dump      = chip_stb && cnt_last && !sync;
      end
    endcase
  end

  always_comb begin
    prod    = (in_sample == in_code) ? ACC_W'(1) : '1;
    acc_sum = acc + prod;
    xfer    = out_valid && out_ready;
  end

  epoch_counter #(
    .CHIPS (CHIPS)
  ) u_epoch_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (restart),
    .enable (chip_take),
    .count  (chip_cnt),
    .last   (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (restart) begin
      acc <= chip_take ? prod : '0;
    end else if (dump) begin
      acc <= '0;
    end else if (chip_take) begin
      acc <= acc_sum;
    end
  end

  // A dump landing on a held result is dropped; one landing on a transfer replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_acc   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (dump) begin
      if (!out_valid || out_ready) begin
        out_acc   <= acc_sum;
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
